// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps,
// then one sign-fix cycle and a one-cycle writeback strobe.
module muldiv_unit #(
    parameter int data_width = 32,
    parameter int iter_count = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  kill,
    input  logic [2:0]            funct3,
    input  logic [data_width-1:0] rs1_data,
    input  logic [data_width-1:0] rs2_data,
    input  logic [4:0]            rd_addr,
    output logic                  busy,
    output logic                  done,
    output logic [data_width-1:0] result,
    output logic [4:0]            wb_addr,
    output logic                  wb_en
);
    localparam int CNT_W = $clog2(iter_count);
    localparam int W2    = 2 * data_width;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [data_width-1:0] MIN_NEG = {1'b1, {(data_width-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        counter;
    logic [2:0]              op_q;
    logic [data_width-1:0]   a_q, b_q, mag_a_q, mag_b_q;
    logic                    neg_q;
    logic [W2-1:0]           acc_q;
    logic [4:0]              rd_q;

    logic                    sa_in, sb_in, neg_in;
    logic [data_width:0]     mul_sum, div_rs, div_nr;
    logic                    div_ge;
    logic [W2-1:0]           prod;
    logic [data_width-1:0]   fix_val;

    function automatic logic [data_width-1:0] cond_neg(input logic [data_width-1:0] v,
                                                       input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [W2-1:0] cond_neg_wide(input logic [W2-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    // Operand sign decode at acceptance
    always_comb begin
        sa_in  = 1'b0;
        sb_in  = 1'b0;
        neg_in = 1'b0;
        if (funct3[2]) begin
            sa_in  = ~funct3[0] & rs1_data[data_width-1];
            sb_in  = ~funct3[0] & rs2_data[data_width-1];
            // remainder follows the dividend, quotient follows sign(A)^sign(B)
            neg_in = funct3[1] ? sa_in : (sa_in ^ sb_in);
        end else begin
            sa_in  = ((funct3 == OP_MULH) || (funct3 == OP_MULHSU)) & rs1_data[data_width-1];
            sb_in  = (funct3 == OP_MULH) & rs2_data[data_width-1];
            neg_in = sa_in ^ sb_in;
        end
    end

    // One iteration step: acc holds {partial, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum = {1'b0, acc_q[W2-1:data_width]} + {1'b0, (acc_q[0] ? mag_a_q : '0)};
        div_rs  = {acc_q[W2-1:data_width], acc_q[data_width-1]};
        div_ge  = (div_rs >= {1'b0, mag_b_q});
        div_nr  = div_ge ? (div_rs - {1'b0, mag_b_q}) : div_rs;
    end

    // Result selection and special cases
    always_comb begin
        prod    = cond_neg_wide(acc_q, neg_q);
        fix_val = '0;
        if (!op_q[2]) begin
            fix_val = (op_q == OP_MUL) ? prod[data_width-1:0] : prod[W2-1:data_width];
        end else if (b_q == '0) begin
            fix_val = op_q[1] ? a_q : '1;
        end else if (!op_q[0] && (a_q == MIN_NEG) && (b_q == '1)) begin
            fix_val = op_q[1] ? '0 : MIN_NEG;
        end else begin
            fix_val = cond_neg(op_q[1] ? acc_q[W2-1:data_width] : acc_q[data_width-1:0], neg_q);
        end
    end

    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = CALC;
                CALC:    if (counter == CNT_W'(iter_count - 1)) state_nxt = FIX;
                FIX:     state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            rd_q    <= '0;
            result  <= '0;
            wb_addr <= '0;
        end else if (!kill) begin
            case (state)
                IDLE: if (start) begin
                    counter <= '0;
                    op_q    <= funct3;
                    a_q     <= rs1_data;
                    b_q     <= rs2_data;
                    mag_a_q <= cond_neg(rs1_data, sa_in);
                    mag_b_q <= cond_neg(rs2_data, sb_in);
                    neg_q   <= neg_in;
                    rd_q    <= rd_addr;
                    acc_q   <= {{data_width{1'b0}},
                                (funct3[2] ? cond_neg(rs1_data, sa_in) : cond_neg(rs2_data, sb_in))};
                end
                CALC: begin
                    counter <= counter + CNT_W'(1);
                    if (op_q[2]) acc_q <= {div_nr[data_width-1:0], acc_q[data_width-2:0], div_ge};
                    else         acc_q <= {mul_sum, acc_q[data_width-1:1]};
                end
                FIX: begin
                    result  <= fix_val;
                    wb_addr <= rd_q;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign wb_en = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed RV32M results, latency,
// start-ignore, kill and reset behaviour.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        busy, done, wb_en;
    logic [31:0] result;
    logic [4:0]  wb_addr;

    int checks = 0;
    int errors = 0;

    int          done_cycle, n_done, busy_err, wben_err;
    logic [31:0] res_done, snap_result;
    logic [4:0]  addr_done, snap_addr;

    always #5 clk = ~clk;

    muldiv_unit #(.data_width(32), .iter_count(32)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
        .busy(busy), .done(done), .result(result), .wb_addr(wb_addr), .wb_en(wb_en)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Start an op at edge 0, watch cycles 1..40; optional restart/kill/rst in a given cycle
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int restart_c, input int kill_c,
                          input int rst_c);
        int stop_c;
        logic exp_busy;
        stop_c = (kill_c > 0) ? kill_c : rst_c;
        @(negedge clk);
        funct3 = f3; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
        done_cycle = -1; n_done = 0; busy_err = 0; wben_err = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            exp_busy = (stop_c > 0) ? (c <= stop_c) : (c <= 34);
            if (busy !== exp_busy) busy_err++;
            if (wb_en !== done) wben_err++;
            if (done === 1'b1) begin
                n_done++;
                if (done_cycle < 0) begin
                    done_cycle = c; res_done = result; addr_done = wb_addr;
                end
            end
            if (stop_c > 0 && c == stop_c + 1) begin
                snap_result = result; snap_addr = wb_addr;
            end
            start = 1'b0; kill = 1'b0; rst = 1'b0;
            if (c == restart_c) begin
                start = 1'b1; rs1_data = 32'd100; rs2_data = 32'd100;
                funct3 = 3'b011; rd_addr = 5'd9;
            end
            if (c == kill_c) kill = 1'b1;
            if (c == rst_c) rst = 1'b1;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        run_op(f3, a, b, rd, 0, 0, 0);
        check(tag, res_done, exp);
        check({tag, "_lat"}, done_cycle, 34);
        check({tag, "_addr"}, {27'b0, addr_done}, {27'b0, rd});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_wben", {31'b0, wb_en}, 0);
        check("rst_result", result, 0);
        check("rst_wbaddr", {27'b0, wb_addr}, 0);
        rst = 1'b0;

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, 0, 0);
        check("mul_busy_window", busy_err, 0);
        check("mul_wben_eq_done", wben_err, 0);
        check("mul_npulse", n_done, 1);
        check("mul_lat", done_cycle, 34);
        check("mul_result", res_done, 32'hFFFF_FFEB);
        check("mul_wbaddr", {27'b0, addr_done}, 32'd5);

        do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF);
        do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
        do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
        do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
        do_op("divu",   3'b101, 32'd100, 32'd7, 5'd7, 32'd14);
        do_op("remu",   3'b111, 32'd100, 32'd7, 5'd8, 32'd2);
        do_op("divu_z", 3'b101, 32'd100, 32'd0, 5'd10, 32'hFFFF_FFFF);
        do_op("remu_z", 3'b111, 32'd100, 32'd0, 5'd11, 32'd100);
        do_op("div_z",  3'b100, 32'hFFFF_FFF9, 32'd0, 5'd12, 32'hFFFF_FFFF);
        do_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
        do_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'd0);

        run_op(3'b000, 32'd3, 32'd4, 5'd6, 10, 0, 0);
        check("restart_result", res_done, 32'd12);
        check("restart_lat", done_cycle, 34);
        check("restart_npulse", n_done, 1);
        check("restart_wbaddr", {27'b0, addr_done}, 32'd6);
        check("restart_busy", busy_err, 0);

        do_op("accept_after", 3'b101, 32'd100, 32'd7, 5'd14, 32'd14);

        run_op(3'b101, 32'd50, 32'd3, 5'd15, 0, 15, 0);
        check("kill_busy", busy_err, 0);
        check("kill_npulse", n_done, 0);
        check("kill_result_hold", snap_result, 32'd14);
        check("kill_wbaddr_hold", {27'b0, snap_addr}, 32'd14);

        run_op(3'b000, 32'd5, 32'd6, 5'd16, 0, 0, 20);
        check("rst_mid_busy", busy_err, 0);
        check("rst_mid_npulse", n_done, 0);
        check("rst_mid_result", snap_result, 0);
        check("rst_mid_wbaddr", {27'b0, snap_addr}, 0);

        @(negedge clk);
        funct3 = 3'b000; rs1_data = 32'd2; rs2_data = 32'd2; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("start_kill_busy", {31'b0, busy}, 0);
        repeat (3) @(negedge clk);
        check("start_kill_busy_later", {31'b0, busy}, 0);

        do_op("mul_final", 3'b000, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 5'd17, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
